// File: rtl/div_sched.sv
// Two-requester front end for a shared 16-iteration radix-4 divider.
// Round-robin grant, bypass of trivial cases, last-result cache, WAIT timeout and flush.
//
// state  | meaning
// IDLE   | arbitrate requesters; resolve bypass / cache hit or launch divider
// LAUNCH | one-cycle div_en pulse with latched operands
// WAIT   | wait for div_fin, bounded by TIMEOUT cycles
// RESP   | hold response until resp_ready
module div_sched #(
   parameter int CACHE_EN = 1,
   parameter int TIMEOUT  = 31
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [31:0] req0_dividend,
   input  logic [31:0] req0_divisor,
   input  logic        req0_uns,
   input  logic        req0_rem,
   input  logic [31:0] req1_dividend,
   input  logic [31:0] req1_divisor,
   input  logic        req1_uns,
   input  logic        req1_rem,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic        resp_id,
   output logic [31:0] resp_data,
   output logic        resp_err,
   input  logic        flush,
   output logic        busy,
   output logic [31:0] div_dividend,
   output logic [31:0] div_divisor,
   output logic        div_uns,
   output logic        div_en,
   output logic        div_rstn,
   input  logic [31:0] div_quot,
   input  logic [31:0] div_rem,
   input  logic        div_fin
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

   state_t      state, state_nx;
   logic        rr_ptr;
   logic [31:0] op_dividend, op_divisor;
   logic        op_uns, op_rem, op_id;
   logic [31:0] res_quot, res_rem;
   logic        res_err;
   logic [31:0] c_dividend, c_divisor, c_quot, c_rem;
   logic        c_uns, c_valid;
   logic [TW-1:0] wait_cnt;

   logic        grant, sel_id, sel_uns, sel_rem;
   logic [31:0] sel_dividend, sel_divisor;
   logic        is_div0, is_ovf, is_hit;
   logic        fin_ok, tmo, abort, drive_div;

   always_comb begin
      sel_id = (req_valid == 2'b11) ? rr_ptr : req_valid[1];
      grant  = (state == IDLE) && !flush && !rst && (req_valid != 2'b00);
      req_ready = 2'b00;
      if (grant) req_ready = sel_id ? 2'b10 : 2'b01;
      sel_dividend = sel_id ? req1_dividend : req0_dividend;
      sel_divisor  = sel_id ? req1_divisor  : req0_divisor;
      sel_uns      = sel_id ? req1_uns      : req0_uns;
      sel_rem      = sel_id ? req1_rem      : req0_rem;
      is_div0 = (sel_divisor == 32'h0);
      is_ovf  = !sel_uns && (sel_dividend == 32'h8000_0000) && (sel_divisor == 32'hFFFF_FFFF);
      is_hit  = (CACHE_EN != 0) && c_valid && (c_dividend == sel_dividend)
                && (c_divisor == sel_divisor) && (c_uns == sel_uns);
      fin_ok  = (state == WAIT) && div_fin;
      tmo     = (state == WAIT) && !div_fin && (wait_cnt == '0);
      abort   = ((state == LAUNCH) || (state == WAIT)) && flush;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:   if (grant) state_nx = (is_div0 || is_ovf || is_hit) ? RESP : LAUNCH;
         LAUNCH: state_nx = flush ? IDLE : WAIT;
         WAIT: begin
            if (flush)             state_nx = IDLE;
            else if (fin_ok || tmo) state_nx = RESP;
         end
         RESP:   if (flush || resp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      resp_valid = (state == RESP) && !rst;
      resp_id    = resp_valid && op_id;
      resp_err   = resp_valid && res_err;
      resp_data  = '0;
      if (resp_valid && !res_err) resp_data = op_rem ? res_rem : res_quot;
      busy       = (state != IDLE) && !rst;
      drive_div  = ((state == LAUNCH) || (state == WAIT)) && !rst;
      div_dividend = drive_div ? op_dividend : '0;
      div_divisor  = drive_div ? op_divisor  : '0;
      div_uns      = drive_div && op_uns;
      div_en       = (state == LAUNCH) && !rst;
      // divider is reset on abort, on timeout, and throughout our own reset
      div_rstn     = !(rst || abort || tmo);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         rr_ptr      <= 1'b0;
         op_dividend <= '0;
         op_divisor  <= '0;
         op_uns      <= 1'b0;
         op_rem      <= 1'b0;
         op_id       <= 1'b0;
         res_quot    <= '0;
         res_rem     <= '0;
         res_err     <= 1'b0;
         c_dividend  <= '0;
         c_divisor   <= '0;
         c_uns       <= 1'b0;
         c_quot      <= '0;
         c_rem       <= '0;
         c_valid     <= 1'b0;
         wait_cnt    <= '0;
      end else begin
         state <= state_nx;
         if (grant) begin
            rr_ptr      <= ~sel_id;
            op_dividend <= sel_dividend;
            op_divisor  <= sel_divisor;
            op_uns      <= sel_uns;
            op_rem      <= sel_rem;
            op_id       <= sel_id;
            res_err     <= 1'b0;
            if (is_div0) begin
               res_quot <= 32'hFFFF_FFFF;
               res_rem  <= sel_dividend;
            end else if (is_ovf) begin
               res_quot <= 32'h8000_0000;
               res_rem  <= '0;
            end else if (is_hit) begin
               res_quot <= c_quot;
               res_rem  <= c_rem;
            end
         end
         if (state == LAUNCH)
            wait_cnt <= TW'(TIMEOUT - 1);
         else if ((state == WAIT) && (wait_cnt != '0))
            wait_cnt <= wait_cnt - TW'(1);
         if (fin_ok && !flush) begin
            res_quot <= div_quot;
            res_rem  <= div_rem;
            res_err  <= 1'b0;
            if (CACHE_EN != 0) begin
               c_dividend <= op_dividend;
               c_divisor  <= op_divisor;
               c_uns      <= op_uns;
               c_quot     <= div_quot;
               c_rem      <= div_rem;
               c_valid    <= 1'b1;
            end
         end
         if (tmo && !flush) res_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched with a behavioural 16-iteration divider and a response scoreboard.
module tb_div_sched;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [1:0]  req_valid, req_ready;
   logic [31:0] req0_dividend, req0_divisor, req1_dividend, req1_divisor;
   logic        req0_uns, req0_rem, req1_uns, req1_rem;
   logic        resp_valid, resp_ready, resp_id, resp_err;
   logic [31:0] resp_data;
   logic        flush, busy;
   logic [31:0] div_dividend, div_divisor, div_quot, div_rem;
   logic        div_uns, div_en, div_rstn, div_fin;

   div_sched #(.CACHE_EN(1), .TIMEOUT(31)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req0_dividend(req0_dividend), .req0_divisor(req0_divisor),
      .req0_uns(req0_uns), .req0_rem(req0_rem),
      .req1_dividend(req1_dividend), .req1_divisor(req1_divisor),
      .req1_uns(req1_uns), .req1_rem(req1_rem),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_id(resp_id), .resp_data(resp_data), .resp_err(resp_err),
      .flush(flush), .busy(busy),
      .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_uns(div_uns), .div_en(div_en), .div_rstn(div_rstn),
      .div_quot(div_quot), .div_rem(div_rem), .div_fin(div_fin)
   );

   // divider model: finishes in the 16th cycle after the div_en cycle
   logic [4:0]  dcnt;
   logic        dact = 1'b0;
   logic [31:0] da, db;
   logic        du;
   logic        div_hang;
   int          cyc = 0;
   int          en_cnt = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (div_en) en_cnt <= en_cnt + 1;
      if (!div_rstn) dact <= 1'b0;
      else if (div_en) begin
         dact <= 1'b1;
         dcnt <= 5'd15;
         da   <= div_dividend;
         db   <= div_divisor;
         du   <= div_uns;
      end else if (dact && dcnt != 5'd0) dcnt <= dcnt - 5'd1;
   end

   always_comb begin
      div_fin  = dact && (dcnt == 5'd0) && !div_hang;
      div_quot = '0;
      div_rem  = '0;
      if (db != 32'd0) begin
         if (du) begin
            div_quot = da / db;
            div_rem  = da % db;
         end else begin
            div_quot = $signed(da) / $signed(db);
            div_rem  = $signed(da) % $signed(db);
         end
      end
   end

   typedef struct {
      logic        id;
      logic [31:0] data;
      logic        err;
   } exp_t;
   exp_t sb[$];

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void push(input logic id, input logic [31:0] data, input logic err);
      exp_t e;
      e.id = id; e.data = data; e.err = err;
      sb.push_back(e);
   endfunction

   // called at a negedge; returns at the negedge after the handshake cycle
   task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] b,
                        input logic uns, input logic rem, output int hs);
      int n;
      n = 0;
      if (id) begin
         req1_dividend = a; req1_divisor = b; req1_uns = uns; req1_rem = rem;
      end else begin
         req0_dividend = a; req0_divisor = b; req0_uns = uns; req0_rem = rem;
      end
      req_valid[id] = 1'b1;
      #1;
      while (!req_ready[id] && n < 40) begin
         @(negedge clk); #1; n++;
      end
      chk("issue_ready", req_ready[id], 1'b1);
      hs = cyc;
      @(posedge clk); @(negedge clk);
      req_valid[id] = 1'b0;
   endtask

   task automatic wait_resp(input string tag, input int hs, input int lat, input int hold,
                            output int busy_lo);
      int n;
      exp_t e;
      logic [31:0] snap;
      bit stable;
      n = 0;
      busy_lo = 0;
      while (!resp_valid && n < 60) begin
         if (!busy) busy_lo++;
         @(negedge clk); n++;
      end
      chk({tag, "_valid"}, resp_valid, 1'b1);
      if (lat >= 0) chk({tag, "_lat"}, cyc - hs, lat);
      chk({tag, "_sb_nonempty"}, sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, "_id"}, resp_id, e.id);
         chk({tag, "_data"}, resp_data, e.data);
         chk({tag, "_err"}, resp_err, e.err);
      end
      if (hold > 0) begin
         snap = resp_data;
         stable = 1'b1;
         repeat (hold) begin
            @(posedge clk); @(negedge clk);
            if (!resp_valid || resp_data !== snap || req_ready != 2'b00) stable = 1'b0;
         end
         chk({tag, "_hold"}, stable, 1'b1);
      end
      resp_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      resp_ready = 1'b0;
      chk({tag, "_done"}, resp_valid, 1'b0);
   endtask

   initial begin
      int hs, bz, en0, seen;
      rst = 1'b1; flush = 1'b0; resp_ready = 1'b0; div_hang = 1'b0;
      req_valid = 2'b11;
      req0_dividend = 32'd5; req0_divisor = 32'd1; req0_uns = 1'b1; req0_rem = 1'b0;
      req1_dividend = 32'd6; req1_divisor = 32'd1; req1_uns = 1'b1; req1_rem = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", req_ready, 2'b00);
      chk("rst_resp_ctl", {resp_valid, resp_id, resp_err, busy}, 4'b0);
      chk("rst_resp_data", resp_data, 32'd0);
      chk("rst_div_ctl", {div_en, div_rstn, div_uns}, 3'b0);
      chk("rst_div_ops", {div_dividend, div_divisor}, 64'd0);
      req_valid = 2'b00;
      rst = 1'b0;
      @(negedge clk);
      chk("idle_rstn", {div_rstn, busy}, 2'b10);

      // unsigned 100/7 through the divider
      issue(1'b0, 32'd100, 32'd7, 1'b1, 1'b0, hs);
      push(1'b0, 32'd14, 1'b0);
      en0 = en_cnt;
      wait_resp("q100_7", hs, 18, 0, bz);
      chk("q100_7_busy_low", bz, 0);
      chk("q100_7_en_pulses", en_cnt - en0, 1);

      // signed -7/2 remainder, then cache hit for the quotient
      issue(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, hs);
      push(1'b1, 32'hFFFF_FFFF, 1'b0);
      wait_resp("s_rem", hs, 18, 0, bz);
      en0 = en_cnt;
      issue(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, hs);
      push(1'b1, 32'hFFFF_FFFD, 1'b0);
      wait_resp("s_hit", hs, 1, 0, bz);
      chk("s_hit_no_en", en_cnt - en0, 0);

      // bypass cases
      en0 = en_cnt;
      issue(1'b0, 32'h1234, 32'd0, 1'b1, 1'b0, hs);
      push(1'b0, 32'hFFFF_FFFF, 1'b0);
      wait_resp("dz_quot", hs, 1, 0, bz);
      issue(1'b0, 32'h1234, 32'd0, 1'b1, 1'b1, hs);
      push(1'b0, 32'h1234, 1'b0);
      wait_resp("dz_rem", hs, 1, 0, bz);
      issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, hs);
      push(1'b1, 32'h8000_0000, 1'b0);
      wait_resp("ovf_quot", hs, 1, 0, bz);
      issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, hs);
      push(1'b1, 32'd0, 1'b0);
      wait_resp("ovf_rem", hs, 1, 0, bz);
      chk("bypass_no_en", en_cnt - en0, 0);

      // flush in the sixth WAIT cycle
      issue(1'b0, 32'd1000, 32'd10, 1'b1, 1'b0, hs);
      while (cyc < hs + 7) @(negedge clk);
      flush = 1'b1;
      #1;
      chk("flush_rstn_low", {div_rstn, busy}, 2'b01);
      @(posedge clk); @(negedge clk);
      flush = 1'b0;
      chk("flush_after", {div_rstn, busy, resp_valid}, 3'b100);
      seen = 0;
      repeat (25) begin
         @(negedge clk);
         if (resp_valid || busy) seen++;
      end
      chk("flush_no_resp", seen, 0);
      issue(1'b0, 32'd1000, 32'd10, 1'b1, 1'b0, hs);
      push(1'b0, 32'd100, 1'b0);
      wait_resp("post_flush", hs, 18, 0, bz);

      // round robin with both requesters continuously valid
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      req0_dividend = 32'd50; req0_divisor = 32'd5; req0_uns = 1'b1; req0_rem = 1'b0;
      req1_dividend = 32'd60; req1_divisor = 32'd4; req1_uns = 1'b1; req1_rem = 1'b0;
      req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         int n;
         n = 0;
         #1;
         while (req_ready == 2'b00 && n < 40) begin
            @(negedge clk); #1; n++;
         end
         chk($sformatf("rr_grant%0d", k), req_ready, (k % 2 == 1) ? 2'b10 : 2'b01);
         push(k % 2 == 1, (k % 2 == 1) ? 32'd15 : 32'd10, 1'b0);
         @(posedge clk); @(negedge clk);
         wait_resp($sformatf("rr%0d", k), 0, -1, (k == 0) ? 5 : 0, bz);
      end
      req_valid = 2'b00;

      // divider that never finishes
      div_hang = 1'b1;
      issue(1'b0, 32'd77, 32'd7, 1'b1, 1'b0, hs);
      push(1'b0, 32'd0, 1'b1);
      while (cyc < hs + 32) @(negedge clk);
      chk("tmo_rstn_low", div_rstn, 1'b0);
      wait_resp("tmo", hs, 33, 0, bz);
      div_hang = 1'b0;
      issue(1'b0, 32'd77, 32'd7, 1'b1, 1'b0, hs);
      push(1'b0, 32'd11, 1'b0);
      wait_resp("tmo_nocache", hs, 18, 0, bz);

      // reset in the middle of WAIT
      issue(1'b1, 32'd89, 32'd8, 1'b1, 1'b0, hs);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_ctl", {req_ready, resp_valid, resp_id, resp_err, busy, div_en, div_rstn, div_uns}, 9'd0);
      chk("mid_rst_data", resp_data, 32'd0);
      chk("mid_rst_ops", {div_dividend, div_divisor}, 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (25) begin
         @(negedge clk);
         if (resp_valid || busy) seen++;
      end
      chk("mid_rst_no_resp", seen, 0);
      issue(1'b1, 32'd89, 32'd8, 1'b1, 1'b1, hs);
      push(1'b1, 32'd1, 1'b0);
      wait_resp("post_rst", hs, 18, 0, bz);

      chk("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/div_sched.md
DIV_SCHED -- requirements
Module: div_sched

Interface
- REQ-001 SHALL have parameter CACHE_EN, default 1; 1 enables the last-result cache (REQ-019).
- REQ-002 SHALL have parameter TIMEOUT, default 31; maximum WAIT cycles before abort (REQ-021).
- REQ-003 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
- REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
- REQ-005 SHALL have ports req_valid / req_ready, input / output, 2 each: per-requester handshake; bit i belongs to requester i.
- REQ-006 SHALL have ports reqN_dividend / reqN_divisor, input, 32 each (N=0,1): operands.
- REQ-007 SHALL have ports reqN_uns / reqN_rem, input, 1 each: unsigned-op flag; 1 returns the remainder, 0 returns the quotient.
- REQ-008 SHALL have ports resp_valid, output, 1; resp_ready, input, 1: response handshake.
- REQ-009 SHALL have ports resp_id, output, 1; resp_data, output, 32; resp_err, output, 1: originating requester, result, timeout flag.
- REQ-010 SHALL have ports flush, input, 1; busy, output, 1: abort request; high whenever state is not IDLE.
- REQ-011 SHALL have ports div_dividend / div_divisor, output, 32; div_uns / div_en / div_rstn, output, 1: drive the shared 16-iteration radix-4 divider.
- REQ-012 SHALL have ports div_quot / div_rem, input, 32; div_fin, input, 1: divider results and finish level.

Function
- REQ-013 SHALL implement states IDLE, LAUNCH, WAIT, RESP.
- REQ-014 IDLE SHALL use round-robin arbitration between requesters.
  - If both req_valid bits are high, grant the requester not granted last; the pointer is 0 after reset.
  - req_ready SHALL be high for the granted bit only, combinationally, and only in IDLE with flush low.
  - The handshake cycle SHALL latch dividend, divisor, uns, rem and id.
- REQ-015 A divisor of zero SHALL bypass the divider and go directly to RESP with quot=0xFFFFFFFF and rem=dividend.
- REQ-016 A signed operation (uns=0) with dividend 0x80000000 and divisor 0xFFFFFFFF SHALL bypass the divider and go to RESP with quot=0x80000000 and rem=0.
- REQ-017 All other operations SHALL go IDLE->LAUNCH.
  - LAUNCH SHALL assert div_en for exactly one cycle, then move to WAIT.
  - div_dividend, div_divisor and div_uns SHALL hold the latched operands from LAUNCH through the WAIT exit cycle; they are 0 otherwise.
- REQ-018 WAIT SHALL treat div_fin=1 as completion.
  - On completion, capture div_quot and div_rem and move to RESP.
  - With the companion divider, resp_valid SHALL first assert 18 cycles after the request handshake cycle.
- REQ-019 With CACHE_EN=1, the cache SHALL hold {dividend, divisor, uns, quot, rem, valid} of the last divider-completed operation.
  - A request matching dividend, divisor and uns while valid=1 SHALL go IDLE->RESP, with resp_valid on the next cycle.
  - Bypass (REQ-015/016) results SHALL NOT update the cache.
  - A cache hit SHALL take priority over the divider path; REQ-015/016 SHALL take priority over the cache.
- REQ-020 RESP SHALL hold resp_valid, resp_id, resp_err and resp_data stable until resp_ready=1.
  - resp_data SHALL be rem if the latched rem flag is 1, otherwise quot.
  - The transfer cycle SHALL return to IDLE; no new grant SHALL occur in that same cycle.
- REQ-021 If WAIT lasts TIMEOUT cycles without div_fin, the block SHALL:
  - drive div_rstn=0 for one cycle;
  - go to RESP with resp_err=1 and resp_data=0;
  - not update the cache.
- REQ-022 flush=1 in LAUNCH or WAIT SHALL:
  - drive div_rstn=0 for one cycle;
  - return to IDLE with no response and no cache update.
- REQ-023 flush=1 in RESP SHALL drop the pending response and return to IDLE.
- REQ-024 flush=1 in IDLE SHALL force req_ready=0.
- REQ-025 flush SHALL NOT clear the cache valid bit.
- REQ-026 div_rstn SHALL be 1 except in the cases of REQ-021, REQ-022 and REQ-027.

Reset
- REQ-027 While rst=1, the block SHALL:
  - enter IDLE;
  - drive req_ready=0, resp_valid=0, resp_id=0, resp_data=0, resp_err=0, busy=0;
  - drive div_en=0, div_rstn=0, and div_dividend, div_divisor, div_uns = 0;
  - set the cache valid bit to 0 and the round-robin pointer to 0.
- REQ-028 rst asserted mid-operation SHALL discard the operation with no response; the first cycle after rst deasserts SHALL behave as IDLE.

Verification
- REQ-029 The bench SHALL check: req0 unsigned 100/7, rem=0 -> resp_data=14, resp_id=0, resp_valid 18 cycles after handshake, busy high throughout.
- REQ-030 The bench SHALL check: req1 signed 0xFFFFFFF9 / 2 with rem=1, then the same operands with rem=0 -> first resp_data=0xFFFFFFFF; second is a cache hit, resp_data=0xFFFFFFFD, resp_valid one cycle after handshake.
- REQ-031 The bench SHALL check: divisor 0 with dividend 0x1234 -> quot 0xFFFFFFFF or rem 0x1234, one-cycle latency, div_en never asserted; signed 0x80000000 / 0xFFFFFFFF -> quot 0x80000000.
- REQ-032 The bench SHALL check: both requesters valid continuously -> grants alternate 0,1,0,1; resp_ready held low for 5 cycles -> response data held stable, no new grant.
- REQ-033 The bench SHALL check: flush in WAIT cycle 6 -> div_rstn low one cycle, no response, next request completes correctly.
- REQ-034 The bench SHALL check: a divider model that never raises div_fin -> resp_err=1, resp_data=0 after 31 WAIT cycles; rst mid-WAIT -> all outputs at reset values.
